// File: rtl/i2cm_reg_bank.sv
// Paged host register bank for an N-channel I2C master.
// Page index register at 8'hFF selects either the config page (per-channel
// control, trigger/busy, sticky W1C status, IRQ enables) or the data page
// (byte buffer shared with the master engines through dedicated ports).
module i2cm_reg_bank #(
  parameter int         NUM_CH     = 2,
  parameter int         DATA_DEPTH = 32,
  parameter logic [3:0] PAGE_CFG   = 4'hA,
  parameter logic [3:0] PAGE_DATA  = 4'hE
) (
  input  logic                  i2csf_clk,
  input  logic                  i2csf_rst_n,
  input  logic                  reg_we,
  input  logic [7:0]            reg_addr,
  input  logic [7:0]            reg_wdata,
  output logic [7:0]            reg_rdata,
  input  logic [NUM_CH-1:0]     i_i2cm_finish_tgl,
  input  logic [NUM_CH-1:0]     i_i2cm_nack_ntfy_tgl,
  input  logic                  i_i2cm_wr_en,
  input  logic [7:0]            i_i2cm_wr_addr,
  input  logic [7:0]            i_i2cm_wr_data,
  input  logic [7:0]            i_i2cm_rd_addr,
  output logic [7:0]            r_i2cm_rd_data,
  output logic [NUM_CH-1:0]     r_i2cm_trg,
  output logic [NUM_CH-1:0]     r_i2cm_seq,
  output logic [NUM_CH-1:0]     r_i2cm_stb,
  output logic [NUM_CH-1:0]     r_i2cm_type,
  output logic [NUM_CH*8-1:0]   r_i2cm_num,
  output logic [NUM_CH*8-1:0]   r_i2cm_dev_id,
  output logic [NUM_CH*8-1:0]   r_i2cm_addr,
  output logic [NUM_CH-1:0]     r_i2cm_busy,
  output logic                  o_irq,
  output logic                  o_wr_collide
);

  // DATA_DEPTH is at most 255, so the limit always fits in a byte.
  localparam logic [7:0] DEPTH_LIM = 8'(DATA_DEPTH);

  logic [3:0]        page_reg;
  logic              idx_sel;
  logic              cfg_wr;
  logic              data_wr;
  logic              irq_reg;
  logic              collide_reg;
  logic [NUM_CH-1:0] irq_src;
  // Full 256-entry array so an 8-bit address indexes it directly; entries at
  // or above DATA_DEPTH are never written and stay at their reset value.
  logic [7:0]        mem_reg [256];
  // Read-mux chain across channels: element gi+1 holds the selected byte so far.
  logic [7:0]        rd_chain [NUM_CH+1];

  assign idx_sel = (reg_addr == 8'hFF);
  assign cfg_wr  = reg_we && !idx_sel && (page_reg == PAGE_CFG);
  assign data_wr = reg_we && !idx_sel && (page_reg == PAGE_DATA);

  // Page index register.
  always_ff @(posedge i2csf_clk) begin
    if (!i2csf_rst_n) begin
      page_reg <= 4'h0;
    end else if (reg_we && idx_sel) begin
      page_reg <= reg_wdata[3:0];
    end
  end

  assign rd_chain[0] = 8'h00;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [2:0] ctrl_reg;    // {type, stb, seq}
      logic [2:0] status_reg;  // {ovr, nack, finish}
      logic [2:0] irq_en_reg;
      logic [7:0] num_reg;
      logic [7:0] dev_reg;
      logic [7:0] adr_reg;
      logic       busy_reg;
      logic       trg_reg;
      logic       fin_d_reg;
      logic       nack_d_reg;
      logic       ch_hit;
      logic       ch_wr;
      logic       fin_edge;
      logic       nack_edge;
      logic       trg_req;
      logic       busy_held;
      logic [2:0] w1c_mask;
      logic [2:0] set_mask;
      logic [7:0] ch_rd;

      assign ch_hit    = (reg_addr[7:3] == 5'(gi));
      assign ch_wr     = cfg_wr && ch_hit;
      assign fin_edge  = i_i2cm_finish_tgl[gi] ^ fin_d_reg;
      assign nack_edge = i_i2cm_nack_ntfy_tgl[gi] ^ nack_d_reg;
      assign trg_req   = ch_wr && (reg_addr[2:0] == 3'd0) && reg_wdata[0];
      // A finish edge in the same cycle frees the channel before the trigger is judged.
      assign busy_held = busy_reg && !fin_edge;
      assign w1c_mask  = (ch_wr && (reg_addr[2:0] == 3'd4)) ? reg_wdata[2:0] : 3'b000;
      assign set_mask  = {trg_req && busy_held, nack_edge, fin_edge};

      // Channel state: toggle history, trigger/busy, sticky status and R/W fields.
      always_ff @(posedge i2csf_clk) begin
        if (!i2csf_rst_n) begin
          ctrl_reg   <= 3'b000;
          status_reg <= 3'b000;
          irq_en_reg <= 3'b000;
          num_reg    <= 8'h00;
          dev_reg    <= 8'h00;
          adr_reg    <= 8'h00;
          busy_reg   <= 1'b0;
          trg_reg    <= 1'b0;
          fin_d_reg  <= 1'b0;
          nack_d_reg <= 1'b0;
        end else begin
          fin_d_reg  <= i_i2cm_finish_tgl[gi];
          nack_d_reg <= i_i2cm_nack_ntfy_tgl[gi];
          trg_reg    <= trg_req && !busy_held;
          busy_reg   <= busy_held || trg_req;
          // Set wins over a simultaneous W1C.
          status_reg <= (status_reg & ~w1c_mask) | set_mask;
          if (ch_wr) begin
            case (reg_addr[2:0])
              3'd0:    ctrl_reg   <= reg_wdata[3:1];
              3'd1:    num_reg    <= reg_wdata;
              3'd2:    dev_reg    <= reg_wdata;
              3'd3:    adr_reg    <= reg_wdata;
              3'd5:    irq_en_reg <= reg_wdata[2:0];
              default: ;
            endcase
          end
        end
      end

      // Host view of this channel's 8-byte window.
      always_comb begin
        ch_rd = 8'h00;
        case (reg_addr[2:0])
          3'd0:    ch_rd = {4'h0, ctrl_reg, 1'b0};
          3'd1:    ch_rd = num_reg;
          3'd2:    ch_rd = dev_reg;
          3'd3:    ch_rd = adr_reg;
          3'd4:    ch_rd = {5'h00, status_reg};
          3'd5:    ch_rd = {5'h00, irq_en_reg};
          default: ch_rd = 8'h00;
        endcase
      end

      assign rd_chain[gi+1]        = ch_hit ? ch_rd : rd_chain[gi];
      assign irq_src[gi]           = |(status_reg & irq_en_reg);
      assign r_i2cm_trg[gi]        = trg_reg;
      assign r_i2cm_busy[gi]       = busy_reg;
      assign r_i2cm_seq[gi]        = ctrl_reg[0];
      assign r_i2cm_stb[gi]        = ctrl_reg[1];
      assign r_i2cm_type[gi]       = ctrl_reg[2];
      assign r_i2cm_num[8*gi +: 8]    = num_reg;
      assign r_i2cm_dev_id[8*gi +: 8] = dev_reg;
      assign r_i2cm_addr[8*gi +: 8]   = adr_reg;
    end
  endgenerate

  // Registered interrupt and host-write collision pulse.
  always_ff @(posedge i2csf_clk) begin
    if (!i2csf_rst_n) begin
      irq_reg     <= 1'b0;
      collide_reg <= 1'b0;
    end else begin
      irq_reg     <= |irq_src;
      collide_reg <= data_wr && i_i2cm_wr_en;
    end
  end

  assign o_irq        = irq_reg;
  assign o_wr_collide = collide_reg;

  // Data buffer: the master write always wins; a colliding host write is dropped.
  always_ff @(posedge i2csf_clk) begin
    if (!i2csf_rst_n) begin
      mem_reg <= '{default: 8'h00};
    end else if (i_i2cm_wr_en) begin
      if (i_i2cm_wr_addr < DEPTH_LIM) begin
        mem_reg[i_i2cm_wr_addr] <= i_i2cm_wr_data;
      end
    end else if (data_wr && (reg_addr < DEPTH_LIM)) begin
      mem_reg[reg_addr] <= reg_wdata;
    end
  end

  assign r_i2cm_rd_data = (i_i2cm_rd_addr < DEPTH_LIM) ? mem_reg[i_i2cm_rd_addr] : 8'h00;

  // Host read mux, combinational from reg_addr.
  always_comb begin
    reg_rdata = 8'h00;
    if (idx_sel) begin
      reg_rdata = {4'h0, page_reg};
    end else if (page_reg == PAGE_CFG) begin
      reg_rdata = rd_chain[NUM_CH];
    end else if ((page_reg == PAGE_DATA) && (reg_addr < DEPTH_LIM)) begin
      reg_rdata = mem_reg[reg_addr];
    end
  end

endmodule
